iter_shifter: RTL and testbench

Multi-cycle, parametrised barrel-shift unit for the microcoded core's execute stage. It is the area-reduced successor to the single-cycle combinational shifter. It shifts by at most STEP bit positions per clock and uses a valid/ready handshake on both sides. Results are bit-identical to a full-width single-cycle shift. A rotate mode can be compiled in.

---
 rtl/iter_shifter_if.sv | 32 +++
 rtl/iter_shifter.sv | 68 ++++++
 tb/tb_iter_shifter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_if.sv
// iter_shifter_if: request/result handshake bundle for iter_shifter; carries rotate only when SUROV_SHIFT_ROTATE_EN is defined
interface iter_shifter_if #(
   parameter int WIDTH = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         val;
   logic [$clog2(WIDTH)-1:0] sham;
   logic                     right_shift;
   logic                     arith_shift;
`ifdef SUROV_SHIFT_ROTATE_EN
   logic                     rotate;
`endif
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out;
   logic                     busy;
   modport master (
`ifdef SUROV_SHIFT_ROTATE_EN
      output rotate,
`endif
      output in_valid, val, sham, right_shift, arith_shift, out_ready,
      input  in_ready, out_valid, out, busy
   );
   modport slave (
`ifdef SUROV_SHIFT_ROTATE_EN
      input  rotate,
`endif
      input  in_valid, val, sham, right_shift, arith_shift, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter moving at most STEP bits per clock; rotate mode compiled in by SUROV_SHIFT_ROTATE_EN
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input logic          clk,
   input logic          rst,
   iter_shifter_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
   localparam logic [SW:0] WID_W  = (SW+1)'(WIDTH);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   logic [1:0]       state;
   logic [SW-1:0]    rem;
   logic [WIDTH-1:0] work;
   logic             rt;
   logic             fill;
   logic [SW:0]      s;
   logic [WIDTH-1:0] nxt;
   logic             accept;
`ifdef SUROV_SHIFT_ROTATE_EN
   logic             ro;
`endif
   assign accept        = state == IDLE && bus.in_valid;
   assign bus.in_ready  = state == IDLE && !rst;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.out       = work;
   // one iteration: shift the working register by min(STEP, rem) with the latched mode
   always_comb begin
      s   = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
      nxt = rt ? ((work >> s) | (fill ? ~({WIDTH{1'b1}} >> s) : '0)) : (work << s);
`ifdef SUROV_SHIFT_ROTATE_EN
      nxt = ro ? (rt ? ((work >> s) | (work << (WID_W - s))) : ((work << s) | (work >> (WID_W - s)))) : nxt;
`endif
   end
   // request capture, iteration and result hand-off
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         work  <= '0;
         rt    <= 1'b0;
         fill  <= 1'b0;
`ifdef SUROV_SHIFT_ROTATE_EN
         ro    <= 1'b0;
`endif
      end else if (accept) begin
         work  <= bus.val;
         rem   <= bus.sham;
         rt    <= bus.right_shift;
         fill  <= bus.right_shift & bus.arith_shift & bus.val[WIDTH-1];
`ifdef SUROV_SHIFT_ROTATE_EN
         ro    <= bus.rotate;
`endif
         state <= (bus.sham == '0) ? DONE : SHIFT;
      end else if (state == SHIFT) begin
         work  <= nxt;
         rem   <= rem - s[SW-1:0];
         state <= ({1'b0, rem} <= STEP_W) ? DONE : SHIFT;
      end else if (state == DONE && bus.out_ready) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: self-checking bench for iter_shifter at STEP 1, 4 and 32; rotate tests need SUROV_SHIFT_ROTATE_EN
module tb_iter_shifter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid[3], right[3], arith[3], rot[3], out_ready[3];
   logic [31:0] val[3];
   logic [4:0]  sham[3];
   logic        in_ready[3], out_valid[3], busy[3];
   logic [31:0] dout[3];
   int          steps[3] = '{1, 4, 32};
   int          checks = 0;
   int          errors = 0;
   // free-running clock
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int ST = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
      iter_shifter_if #(.WIDTH(32)) bus ();
      iter_shifter #(.WIDTH(32), .STEP(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
      assign bus.in_valid    = in_valid[g];
      assign bus.val         = val[g];
      assign bus.sham        = sham[g];
      assign bus.right_shift = right[g];
      assign bus.arith_shift = arith[g];
      assign bus.out_ready   = out_ready[g];
`ifdef SUROV_SHIFT_ROTATE_EN
      assign bus.rotate      = rot[g];
`endif
      assign in_ready[g]  = bus.in_ready;
      assign out_valid[g] = bus.out_valid;
      assign busy[g]      = bus.busy;
      assign dout[g]      = bus.out;
   end
   function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input logic r, input logic a, input logic ro);
      logic [63:0] d;
      d = {v, v};
      if (ro && r) begin
         d = d >> n;
         return d[31:0];
      end
      if (ro) begin
         d = d << n;
         return d[63:32];
      end
      if (r && a) return $signed(v) >>> n;
      if (r) return v >> n;
      return v << n;
   endfunction
   task automatic do_op(input int k, input logic [31:0] v, input logic [4:0] n, input logic r, input logic a, input logic ro, output int lat, output logic [31:0] res);
      val[k] = v; sham[k] = n; right[k] = r; arith[k] = a; rot[k] = ro; in_valid[k] = 1'b1;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      val[k] = $urandom; sham[k] = 5'($urandom); right[k] = 1'($urandom); arith[k] = 1'($urandom); rot[k] = 1'($urandom);
      lat = 1;
      while (!out_valid[k] && lat <= 80) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid[k]) lat = -1;
      res = dout[k];
   endtask
   task automatic release_out(input int k);
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready[k] !== 1'b0) begin errors++; $display("FAIL rst_in_ready[%0d]: got %b expected 0", k, in_ready[k]); end
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks += 4;
         if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, in_ready[k]); end
         if (out_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]); end
         if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
         if (dout[k] !== 32'h0) begin errors++; $display("FAIL reset_out[%0d]: got %h expected 0", k, dout[k]); end
      end
   endtask
   task automatic test_arith;
      int lat; logic [31:0] res;
      do_op(1, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 1'b0, lat, res);
      checks += 2;
      if (lat != 2) begin errors++; $display("FAIL arith_latency: got %0d expected 2", lat); end
      if (res !== 32'hF800_0000) begin errors++; $display("FAIL arith_out: got %h expected f8000000", res); end
      release_out(1);
   endtask
   task automatic test_zero_shift;
      int lat; logic [31:0] res;
      do_op(1, 32'h0000_00FF, 5'd0, 1'b0, 1'b0, 1'b0, lat, res);
      checks += 4;
      if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
      if (res !== 32'h0000_00FF) begin errors++; $display("FAIL zero_out: got %h expected 000000ff", res); end
      if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL zero_in_ready: got %b expected 0", in_ready[1]); end
      if (busy[1] !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", busy[1]); end
      release_out(1);
      checks++;
      if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL zero_idle_ready: got %b expected 1", in_ready[1]); end
   endtask
   task automatic test_backpressure;
      int lat; logic [31:0] res;
      do_op(1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 1'b0, lat, res);
      checks += 2;
      if (lat != 9) begin errors++; $display("FAIL bp_latency: got %0d expected 9", lat); end
      if (res !== 32'h8000_0000) begin errors++; $display("FAIL bp_out: got %h expected 80000000", res); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks += 3;
         if (dout[1] !== 32'h8000_0000) begin errors++; $display("FAIL bp_hold_out: got %h expected 80000000", dout[1]); end
         if (out_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid[1]); end
         if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready: got %b expected 0", in_ready[1]); end
      end
      release_out(1);
   endtask
   task automatic test_rotate;
`ifdef SUROV_SHIFT_ROTATE_EN
      int lat; logic [31:0] res;
      do_op(1, 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1'b1, lat, res);
      checks++;
      if (res !== 32'h7812_3456) begin errors++; $display("FAIL rotr_out: got %h expected 78123456", res); end
      release_out(1);
      do_op(1, 32'h1234_5678, 5'd8, 1'b0, 1'b0, 1'b1, lat, res);
      checks++;
      if (res !== 32'h3456_7812) begin errors++; $display("FAIL rotl_out: got %h expected 34567812", res); end
      release_out(1);
`endif
   endtask
   task automatic test_reset_abort;
      int lat; logic [31:0] res; logic seen;
      val[1] = 32'hDEAD_BEEF; sham[1] = 5'd20; right[1] = 1'b0; arith[1] = 1'b0; rot[1] = 1'b0; in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks += 2;
      if (in_ready[1] !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready[1]); end
      if (busy[1] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy[1]); end
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         seen |= out_valid[1];
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", seen); end
      do_op(1, 32'h1, 5'd1, 1'b0, 1'b0, 1'b0, lat, res);
      checks += 2;
      if (res !== 32'h2) begin errors++; $display("FAIL abort_next_out: got %h expected 2", res); end
      if (lat != 2) begin errors++; $display("FAIL abort_next_latency: got %0d expected 2", lat); end
      release_out(1);
   endtask
   task automatic test_reset_collision;
      val[1] = 32'h5; sham[1] = 5'd0; right[1] = 1'b0; arith[1] = 1'b0; rot[1] = 1'b0; in_valid[1] = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid[1] = 1'b0;
      #1;
      checks += 2;
      if (busy[1] !== 1'b0) begin errors++; $display("FAIL collide_busy: got %b expected 0", busy[1]); end
      if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL collide_out_valid: got %b expected 0", out_valid[1]); end
   endtask
   task automatic test_random;
      int lat, exp_lat; logic [31:0] res, v, exp; logic [4:0] n; logic r, a, ro;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 40; i++) begin
            v = $urandom; n = (i < 2) ? 5'(31 * i) : 5'($urandom); r = 1'($urandom); a = 1'($urandom);
`ifdef SUROV_SHIFT_ROTATE_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            exp = ref_shift(v, int'(n), r, a, ro);
            exp_lat = 1 + (int'(n) + steps[k] - 1) / steps[k];
            checks++;
            if (in_ready[k] !== 1'b1) begin errors++; $display("FAIL rnd_in_ready step%0d: got %b expected 1", steps[k], in_ready[k]); end
            do_op(k, v, n, r, a, ro, lat, res);
            checks += 2;
            if (res !== exp) begin errors++; $display("FAIL rnd_out step%0d val=%h sham=%0d r=%b a=%b ro=%b: got %h expected %h", steps[k], v, n, r, a, ro, res, exp); end
            if (lat != exp_lat) begin errors++; $display("FAIL rnd_latency step%0d sham=%0d: got %0d expected %0d", steps[k], n, lat, exp_lat); end
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(posedge clk);
            #0;
            release_out(k);
         end
      end
   endtask
   // stall guard in case the design never completes a wait
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
   // directed scenarios followed by the randomised sweep
   initial begin
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; right[k] = 1'b0; arith[k] = 1'b0; rot[k] = 1'b0; out_ready[k] = 1'b0;
         val[k] = '0; sham[k] = '0;
      end
      test_reset;
      test_arith;
      test_zero_shift;
      test_backpressure;
      test_rotate;
      test_reset_abort;
      test_reset_collision;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
